gray_frame_writer: RTL and testbench

//  Sink end of the gray pixel stream produced by the RGB-to-gray top (Gray + Done_one strobe, Done_full).

---
 rtl/gray_frame_writer.sv | 122 ++++++++++++
 tb/tb_gray_frame_writer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gray_frame_writer.sv
// gray_frame_writer: captures one gray frame, packs 4 pixels per word and writes the words
// through a small FIFO to a word-addressed frame memory.
module gray_frame_writer #(
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              src_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              short_frame,
  output logic              overflow
);
  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       pack_q, pack_d, push_word;
  logic [PW:0]       wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              short_q, short_d, ovf_q, ovf_d;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic              empty, full, pop, push, wr_en;

  // pointers carry one extra wrap bit to tell full from empty
  assign empty = wp_q == rp_q;
  assign full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign pop   = !empty && mem_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    addr_d  = addr_q + ADDR_W'(pop);
    short_d = short_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CAPTURE;
        cnt_d   = '0;
        idx_d   = '0;
        addr_d  = '0;
        short_d = 1'b0;
        ovf_d   = 1'b0;
      end
      CAPTURE: begin
        if (pix_valid) begin
          pack_d = (idx_q == 2'd0) ? 32'd0 : pack_q;
          pack_d[{idx_q, 3'b000} +: 8] = pix_data;
          idx_d = idx_q + 2'd1;
          cnt_d = cnt_q + CW'(1);
          push  = idx_q == 2'd3;
        end
        // a full pixel count wins over a coincident src_done
        if (cnt_d == CW'(N)) state_d = FLUSH;
        else if (src_done) begin
          short_d = 1'b1;
          state_d = FLUSH;
          if (idx_d != 2'd0) push = 1'b1;
        end
      end
      FLUSH:   if (empty) state_d = DONE;
      default: state_d = IDLE;
    endcase
    push_word = pack_d;
    ovf_d = ovf_d | (push && full && !pop);
    wp_d  = wp_q + (PW+1)'(push && (!full || pop));
    rp_d  = rp_q + (PW+1)'(pop);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pack_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      addr_q  <= '0;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      addr_q  <= addr_d;
      short_q <= short_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) fifo_q[wp_q[PW-1:0]] <= push_word;
  end

  assign mem_we      = !empty;
  assign mem_addr    = addr_q;
  assign mem_wdata   = empty ? 32'd0 : fifo_q[rp_q[PW-1:0]];
  assign busy        = (state_q == CAPTURE) || (state_q == FLUSH);
  assign frame_done  = state_q == DONE;
  assign short_frame = short_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_gray_frame_writer.sv
// tb_gray_frame_writer: randomized frames checked every cycle against a queue-based model,
// plus literal checks of the written words for the directed scenarios.
module tb_gray_frame_writer;
  localparam int W = 4, H = 4, AW = 4, D = 2, N = W * H;
  logic          CLK = 1'b0, RST = 1'b1, start = 1'b0, pix_valid = 1'b0, src_done = 1'b0, mem_ready = 1'b0;
  logic [7:0]    pix_data = 8'd0;
  logic          mem_we, busy, frame_done, short_frame, overflow;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  int            vecs = 0, errs = 0, rdy_pct = 100;

  gray_frame_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .src_done(src_done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .frame_done(frame_done),
    .short_frame(short_frame), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // behavioural model: mode, bytes of the word in progress, queue of words awaiting memory
  int          m_st, m_cnt, m_sz;
  bit          m_pop, m_push;
  logic [31:0] m_w;
  logic [7:0]  m_cur[$];
  logic [31:0] m_q[$];
  logic [AW-1:0] m_addr;
  logic        m_short, m_ovf;
  logic [35:0] wlog[$];

  function automatic logic [31:0] pack(input logic [7:0] b[$]);
    logic [31:0] w = 32'd0;
    foreach (b[i]) w[8*i +: 8] = b[i];
    return w;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_st = 0; m_cnt = 0; m_cur.delete(); m_q.delete(); m_addr = '0; m_short = 0; m_ovf = 0;
    end else begin
      m_sz = m_q.size();
      m_pop = m_sz > 0 && mem_ready;
      m_push = 0;
      m_w = 32'd0;
      case (m_st)
        0: if (start) begin
          m_st = 1; m_cnt = 0; m_cur.delete(); m_addr = '0; m_short = 0; m_ovf = 0;
        end
        1: begin
          if (pix_valid) begin
            m_cur.push_back(pix_data);
            m_cnt++;
            if (m_cur.size() == 4) begin m_w = pack(m_cur); m_push = 1; m_cur.delete(); end
          end
          if (m_cnt == N) m_st = 2;
          else if (src_done) begin
            m_short = 1; m_st = 2;
            if (m_cur.size() > 0) begin m_w = pack(m_cur); m_push = 1; m_cur.delete(); end
          end
        end
        2: if (m_sz == 0) m_st = 3;
        default: m_st = 0;
      endcase
      if (m_pop) begin void'(m_q.pop_front()); m_addr++; end
      if (m_push) begin
        if (m_sz < D || m_pop) m_q.push_back(m_w);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge CLK) begin
    chk("mem_we", 64'(mem_we), 64'(m_q.size() > 0));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_q.size() > 0 ? m_q[0] : 32'd0));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("busy", 64'(busy), 64'(m_st == 1 || m_st == 2));
    chk("frame_done", 64'(frame_done), 64'(m_st == 3));
    chk("short_frame", 64'(short_frame), 64'(m_short));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (mem_we && mem_ready) wlog.push_back({mem_addr, mem_wdata});
  end

  always @(posedge CLK) begin
    #1;
    mem_ready = ($urandom_range(99) < rdy_pct);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic frame(input int n, input logic [7:0] base, input bit sd_last, input bit sd_after,
                       input int gap, input int rd, input int ra, input bit noise);
    int k;
    rdy_pct = rd;
    tick;
    wlog.delete();
    start = 1'b1;
    tick;
    start = noise;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = base + 8'(i);
      src_done  = sd_last && (i == n - 1);
      tick;
      pix_valid = 1'b0;
      src_done  = 1'b0;
      if (i == n - 1) start = 1'b0;
      repeat ($urandom_range(gap)) tick;
    end
    start = 1'b0;
    if (sd_after) begin src_done = 1'b1; tick; src_done = 1'b0; end
    rdy_pct = ra;
    for (k = 0; k < 300 && !frame_done; k++) tick;
    chk("frame_done_seen", 64'(frame_done), 64'd1);
    tick;
  endtask

  initial begin
    repeat (2) tick;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    RST = 1'b0;
    tick;
    frame(16, 8'h01, 0, 0, 0, 100, 100, 0);
    chk("t1_nwrites", 64'(wlog.size()), 64'd4);
    chk("t1_w0", 64'(wlog[0]), 64'({4'd0, 32'h04030201}));
    chk("t1_w3", 64'(wlog[3]), 64'({4'd3, 32'h100F0E0D}));
    chk("t1_flags", 64'({short_frame, overflow}), 64'd0);
    frame(16, 8'h40, 0, 0, 3, 50, 100, 0);
    frame(16, 8'h01, 0, 0, 0, 0, 100, 0);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_nwrites", 64'(wlog.size()), 64'd2);
    chk("t3_w0", 64'(wlog[0]), 64'({4'd0, 32'h04030201}));
    chk("t3_w1", 64'(wlog[1]), 64'({4'd1, 32'h08070605}));
    frame(5, 8'hA0, 0, 1, 0, 100, 100, 0);
    chk("t4_nwrites", 64'(wlog.size()), 64'd2);
    chk("t4_w0", 64'(wlog[0]), 64'({4'd0, 32'hA3A2A1A0}));
    chk("t4_w1", 64'(wlog[1]), 64'({4'd1, 32'h000000A4}));
    chk("t4_flags", 64'({short_frame, overflow}), 64'b10);
    frame(16, 8'h20, 1, 0, 0, 100, 100, 0);
    chk("t5_short", 64'(short_frame), 64'd0);
    chk("t5_nwrites", 64'(wlog.size()), 64'd4);
    chk("t5_w3", 64'(wlog[3]), 64'({4'd3, 32'h2F2E2D2C}));
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 3; i++) begin pix_valid = 1'b1; pix_data = 8'(i); tick; end
    pix_valid = 1'b0;
    RST = 1'b1;
    tick;
    chk("t6_outs", 64'({mem_we, mem_addr, mem_wdata, busy, frame_done, short_frame, overflow}), 64'd0);
    RST = 1'b0;
    tick;
    frame(16, 8'h50, 0, 0, 1, 100, 100, 0);
    chk("t6_w0", 64'(wlog[0]), 64'({4'd0, 32'h53525150}));
    wlog.delete();
    pix_valid = 1'b1;
    repeat (3) tick;
    pix_valid = 1'b0;
    tick;
    chk("t7_idle_busy", 64'(busy), 64'd0);
    chk("t7_idle_writes", 64'(wlog.size()), 64'd0);
    frame(16, 8'h60, 0, 0, 1, 100, 100, 1);
    chk("t7_nwrites", 64'(wlog.size()), 64'd4);
    chk("t7_w0", 64'(wlog[0]), 64'({4'd0, 32'h63626160}));
    for (int r = 0; r < 25; r++) begin
      int  n  = $urandom_range(1, N);
      bit  sl = (n < N) ? bit'($urandom_range(1)) : 1'b0;
      frame(n, 8'($urandom), sl, (n < N) && !sl, $urandom_range(3), $urandom_range(100),
            100, bit'($urandom_range(1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
